// File: rtl/cpu_pkg.sv
// -----------------------------------------------------------------------------
// cpu_pkg
// Shared definitions for the pipeline back end:
//   - load-size encodings used by the MEM and WB stages
//   - datapath / register-index widths
//   - the MEM/WB payload record
// -----------------------------------------------------------------------------
package cpu_pkg;

  localparam int XLEN  = 32;
  localparam int REG_W = 5;

  // Encoding 2'b11 is deliberately left unnamed; consumers treat it as a word.
  typedef enum logic [1:0] {
    LS_BYTE = 2'b00,
    LS_HALF = 2'b01,
    LS_WORD = 2'b10
  } load_size_e;

  // Data fields carried from MEM into WB. Validity is kept separately so that
  // a flush only has to touch one bit.
  typedef struct packed {
    logic             reg_write;
    logic [REG_W-1:0] dest;
    logic [XLEN-1:0]  data;
  } memwb_t;

endpackage : cpu_pkg

// File: rtl/load_align.sv
// -----------------------------------------------------------------------------
// load_align
// Purely combinational extraction of a byte / half / word from an aligned
// little-endian memory word, with sign or zero extension.
//
// Ports:
//   data_i     [31:0]  raw aligned word from data memory
//   size_i     [1:0]   LS_BYTE / LS_HALF / LS_WORD (2'b11 behaves as word)
//   offset_i   [1:0]   byte offset of the load address
//   unsigned_i         1 = zero-extend, 0 = sign-extend sub-word results
//   result_o   [31:0]  extracted, extended value
// -----------------------------------------------------------------------------
module load_align
  import cpu_pkg::*;
(
  input  logic [XLEN-1:0] data_i,
  input  logic [1:0]      size_i,
  input  logic [1:0]      offset_i,
  input  logic            unsigned_i,
  output logic [XLEN-1:0] result_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic        byte_ext;
  logic        half_ext;

  // Byte 0 lives in bits 7:0; the offset scaled by 8 is the lane's LSB.
  assign byte_sel = data_i[{offset_i, 3'b000} +: 8];
  // Halves are selected by offset bit 1 only; bit 0 is ignored.
  assign half_sel = offset_i[1] ? data_i[31:16] : data_i[15:0];

  assign byte_ext = ~unsigned_i & byte_sel[7];
  assign half_ext = ~unsigned_i & half_sel[15];

  // NOTE: result_o gets a default before the case so every path assigns it;
  // otherwise an uncovered encoding would infer a latch.
  always_comb begin
    result_o = data_i;
    case (size_i)
      LS_BYTE: result_o = {{24{byte_ext}}, byte_sel};
      LS_HALF: result_o = {{16{half_ext}}, half_sel};
      default: result_o = data_i;
    endcase
  end

endmodule : load_align

// File: rtl/wb_stage.sv
// -----------------------------------------------------------------------------
// wb_stage
// Write-back pipeline stage: one MEM/WB register feeding the register-file
// write port, same-cycle write-through hits for the ID stage, and a
// retired-instruction counter.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   mem_valid                  MEM presents a valid instruction
//   mem_alu_result [31:0]      ALU / address result
//   mem_load_data  [31:0]      raw aligned load word
//   mem_dest       [4:0]       destination register
//   mem_reg_write              instruction writes the register file
//   mem_to_reg                 1 = load result, 0 = ALU result
//   mem_load_size  [1:0]       byte / half / word
//   mem_load_unsigned          zero- vs sign-extend sub-word loads
//   mem_byte_off   [1:0]       byte offset of the load address
//   flush                      drop the instruction being captured
//   id_rs, id_rt   [4:0]       sources currently decoded in ID
//   we, wb_addr, wb_data       register-file write port (registered)
//   fwd_rs_hit, fwd_rt_hit     write-through hit for rs / rt
//   fwd_data       [31:0]      write-through value (same as wb_data)
//   retire_cnt     [CNT_W-1:0] retired valid instructions, wraps
// -----------------------------------------------------------------------------
module wb_stage
  import cpu_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             mem_valid,
  input  logic [XLEN-1:0]  mem_alu_result,
  input  logic [XLEN-1:0]  mem_load_data,
  input  logic [REG_W-1:0] mem_dest,
  input  logic             mem_reg_write,
  input  logic             mem_to_reg,
  input  logic [1:0]       mem_load_size,
  input  logic             mem_load_unsigned,
  input  logic [1:0]       mem_byte_off,
  input  logic             flush,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  output logic             we,
  output logic [REG_W-1:0] wb_addr,
  output logic [XLEN-1:0]  wb_data,
  output logic             fwd_rs_hit,
  output logic             fwd_rt_hit,
  output logic [XLEN-1:0]  fwd_data,
  output logic [CNT_W-1:0] retire_cnt
);

  logic             valid_d, valid_q;
  memwb_t           wb_d, wb_q;
  logic [CNT_W-1:0] cnt_d, cnt_q;
  logic [XLEN-1:0]  load_value;

  // Extraction happens before the register so the write port is a clean
  // register output in the following cycle.
  load_align u_load_align (
    .data_i     (mem_load_data),
    .size_i     (mem_load_size),
    .offset_i   (mem_byte_off),
    .unsigned_i (mem_load_unsigned),
    .result_o   (load_value)
  );

  // Flush beats valid. Data fields load even for bubbles; only the valid bit
  // gates the write.
  assign valid_d        = mem_valid & ~flush;
  assign wb_d.reg_write = mem_reg_write;
  assign wb_d.dest      = mem_dest;
  assign wb_d.data      = mem_to_reg ? load_value : mem_alu_result;

  // The count lags the instruction by one edge: it advances on the edge where
  // the instruction leaves WB, whether or not it wrote a register.
  assign cnt_d = cnt_q + CNT_W'(valid_q);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its pre-edge inputs regardless of statement order. This block has
  // no memories, so every flop can safely take the asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      wb_q    <= '0;
      cnt_q   <= '0;
    end else begin
      valid_q <= valid_d;
      wb_q    <= wb_d;
      cnt_q   <= cnt_d;
    end
  end

  // Register 0 is hard-wired; writes to it are suppressed here.
  assign we         = valid_q & wb_q.reg_write & (wb_q.dest != '0);
  assign wb_addr    = wb_q.dest;
  assign wb_data    = wb_q.data;
  assign fwd_data   = wb_q.data;
  assign fwd_rs_hit = we & (id_rs == wb_q.dest);
  assign fwd_rt_hit = we & (id_rt == wb_q.dest);
  assign retire_cnt = cnt_q;

endmodule : wb_stage

// File: tb/tb_wb_stage.sv
// -----------------------------------------------------------------------------
// tb_wb_stage
// Directed, table-driven bench for wb_stage (CNT_W = 4 so wrap is reachable),
// plus hand sequences for asynchronous reset and counter wrap.
// -----------------------------------------------------------------------------
module tb_wb_stage;

  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          mem_valid;
  logic [31:0]   mem_alu_result;
  logic [31:0]   mem_load_data;
  logic [4:0]    mem_dest;
  logic          mem_reg_write;
  logic          mem_to_reg;
  logic [1:0]    mem_load_size;
  logic          mem_load_unsigned;
  logic [1:0]    mem_byte_off;
  logic          flush;
  logic [4:0]    id_rs, id_rt;
  logic          we;
  logic [4:0]    wb_addr;
  logic [31:0]   wb_data;
  logic          fwd_rs_hit, fwd_rt_hit;
  logic [31:0]   fwd_data;
  logic [CW-1:0] retire_cnt;

  wb_stage #(.CNT_W(CW)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .mem_valid         (mem_valid),
    .mem_alu_result    (mem_alu_result),
    .mem_load_data     (mem_load_data),
    .mem_dest          (mem_dest),
    .mem_reg_write     (mem_reg_write),
    .mem_to_reg        (mem_to_reg),
    .mem_load_size     (mem_load_size),
    .mem_load_unsigned (mem_load_unsigned),
    .mem_byte_off      (mem_byte_off),
    .flush             (flush),
    .id_rs             (id_rs),
    .id_rt             (id_rt),
    .we                (we),
    .wb_addr           (wb_addr),
    .wb_data           (wb_data),
    .fwd_rs_hit        (fwd_rs_hit),
    .fwd_rt_hit        (fwd_rt_hit),
    .fwd_data          (fwd_data),
    .retire_cnt        (retire_cnt)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Expected retire count: advances on an edge if the previous capture was valid.
  logic [CW-1:0] exp_cnt;
  logic          prev_v;
  logic          cur_v;

  typedef struct {
    logic        valid;
    logic        flush;
    logic        reg_write;
    logic        to_reg;
    logic [1:0]  size;
    logic        uns;
    logic [1:0]  off;
    logic [4:0]  dest;
    logic [31:0] alu;
    logic [31:0] ld;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic        e_we;
    logic [4:0]  e_addr;
    logic [31:0] e_data;
    logic        e_rs;
    logic        e_rt;
  } vec_t;

  localparam int NV = 15;
  vec_t vecs [NV];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic valid, input logic fl, input logic rw,
                              input logic to_reg, input logic [1:0] size,
                              input logic uns, input logic [1:0] off,
                              input logic [4:0] dest, input logic [31:0] alu,
                              input logic [31:0] ld, input logic [4:0] rs,
                              input logic [4:0] rt, input logic e_we,
                              input logic [4:0] e_addr, input logic [31:0] e_data,
                              input logic e_rs, input logic e_rt);
    vec_t v;
    v.valid = valid; v.flush = fl; v.reg_write = rw; v.to_reg = to_reg;
    v.size = size; v.uns = uns; v.off = off; v.dest = dest; v.alu = alu;
    v.ld = ld; v.rs = rs; v.rt = rt; v.e_we = e_we; v.e_addr = e_addr;
    v.e_data = e_data; v.e_rs = e_rs; v.e_rt = e_rt;
    return v;
  endfunction

  task automatic apply(input vec_t v);
    mem_valid         = v.valid;
    flush             = v.flush;
    mem_reg_write     = v.reg_write;
    mem_to_reg        = v.to_reg;
    mem_load_size     = v.size;
    mem_load_unsigned = v.uns;
    mem_byte_off      = v.off;
    mem_dest          = v.dest;
    mem_alu_result    = v.alu;
    mem_load_data     = v.ld;
    id_rs             = v.rs;
    id_rt             = v.rt;
    cur_v             = v.valid & ~v.flush;
  endtask

  // One clock edge; outputs are sampled 2 time units after it.
  task automatic step();
    @(posedge clk);
    exp_cnt = exp_cnt + CW'(prev_v);
    prev_v  = cur_v;
    #2;
  endtask

  task automatic model_reset();
    exp_cnt = '0;
    prev_v  = 1'b0;
  endtask

  initial begin
    // Load size codes: 0 byte, 1 half, 2 word, 3 word.
    vecs[0]  = mk(1,0,1,1, 2'd0,0,2'd2, 5'd5,  32'h0,        32'h8899AABB, 5'd5, 5'd0,
                  1, 5'd5,  32'hFFFFFF99, 1, 0);
    vecs[1]  = mk(1,0,1,1, 2'd0,1,2'd2, 5'd5,  32'h0,        32'h8899AABB, 5'd1, 5'd5,
                  1, 5'd5,  32'h00000099, 0, 1);
    vecs[2]  = mk(1,0,1,1, 2'd1,0,2'd0, 5'd3,  32'h0,        32'h12348000, 5'd3, 5'd3,
                  1, 5'd3,  32'hFFFF8000, 1, 1);
    vecs[3]  = mk(1,0,1,1, 2'd1,1,2'd3, 5'd3,  32'h0,        32'h12348000, 5'd0, 5'd0,
                  1, 5'd3,  32'h00001234, 0, 0);
    vecs[4]  = mk(1,0,1,1, 2'd0,0,2'd0, 5'd8,  32'h0,        32'h8899AABB, 5'd0, 5'd0,
                  1, 5'd8,  32'hFFFFFFBB, 0, 0);
    vecs[5]  = mk(1,0,1,1, 2'd0,1,2'd1, 5'd8,  32'h0,        32'h8899AABB, 5'd0, 5'd8,
                  1, 5'd8,  32'h000000AA, 0, 1);
    vecs[6]  = mk(1,0,1,1, 2'd1,0,2'd2, 5'd10, 32'h0,        32'h8899AABB, 5'd0, 5'd0,
                  1, 5'd10, 32'hFFFF8899, 0, 0);
    vecs[7]  = mk(1,0,1,1, 2'd2,1,2'd3, 5'd11, 32'h0,        32'h8899AABB, 5'd0, 5'd0,
                  1, 5'd11, 32'h8899AABB, 0, 0);
    vecs[8]  = mk(1,0,1,1, 2'd3,0,2'd1, 5'd11, 32'h0,        32'h8899AABB, 5'd0, 5'd0,
                  1, 5'd11, 32'h8899AABB, 0, 0);
    vecs[9]  = mk(1,0,1,0, 2'd0,0,2'd0, 5'd9,  32'h00000055, 32'hFFFFFFFF, 5'd9, 5'd9,
                  1, 5'd9,  32'h00000055, 1, 1);
    vecs[10] = mk(1,0,1,0, 2'd0,0,2'd0, 5'd0,  32'hDEADBEEF, 32'h0,        5'd0, 5'd0,
                  0, 5'd0,  32'hDEADBEEF, 0, 0);
    vecs[11] = mk(1,1,1,0, 2'd0,0,2'd0, 5'd7,  32'hCAFE0007, 32'h0,        5'd7, 5'd0,
                  0, 5'd7,  32'hCAFE0007, 0, 0);
    vecs[12] = mk(0,0,1,0, 2'd0,0,2'd0, 5'd12, 32'h00001111, 32'h0,        5'd12, 5'd12,
                  0, 5'd12, 32'h00001111, 0, 0);
    vecs[13] = mk(1,0,0,0, 2'd0,0,2'd0, 5'd4,  32'h00002222, 32'h0,        5'd4, 5'd0,
                  0, 5'd4,  32'h00002222, 0, 0);
    vecs[14] = mk(1,0,1,1, 2'd1,0,2'd1, 5'd6,  32'h0,        32'h7F007FFF, 5'd0, 5'd6,
                  1, 5'd6,  32'h00007FFF, 0, 1);

    // ---- Reset state ----
    rst_n = 1'b0;
    apply(mk(0,0,0,0,2'd0,0,2'd0,5'd0,32'h0,32'h0,5'd0,5'd0,0,5'd0,32'h0,0,0));
    model_reset();
    repeat (2) @(posedge clk);
    #2;
    check("reset_we",      {31'h0, we},         32'h0);
    check("reset_wb_addr", {27'h0, wb_addr},    32'h0);
    check("reset_wb_data", wb_data,             32'h0);
    check("reset_cnt",     {28'h0, retire_cnt}, 32'h0);
    check("reset_rs_hit",  {31'h0, fwd_rs_hit}, 32'h0);
    rst_n = 1'b1;

    // ---- Table-driven vectors ----
    for (int i = 0; i < NV; i++) begin
      apply(vecs[i]);
      step();
      check($sformatf("v%0d_we", i),       {31'h0, we},         {31'h0, vecs[i].e_we});
      check($sformatf("v%0d_wb_addr", i),  {27'h0, wb_addr},    {27'h0, vecs[i].e_addr});
      check($sformatf("v%0d_wb_data", i),  wb_data,             vecs[i].e_data);
      check($sformatf("v%0d_fwd_data", i), fwd_data,            vecs[i].e_data);
      check($sformatf("v%0d_rs_hit", i),   {31'h0, fwd_rs_hit}, {31'h0, vecs[i].e_rs});
      check($sformatf("v%0d_rt_hit", i),   {31'h0, fwd_rt_hit}, {31'h0, vecs[i].e_rt});
      check($sformatf("v%0d_cnt", i),      {28'h0, retire_cnt}, {28'h0, exp_cnt});
    end

    // ---- Asynchronous reset mid-operation ----
    apply(mk(1,0,1,0,2'd0,0,2'd0,5'd9,32'h55,32'h0,5'd9,5'd9,0,5'd0,32'h0,0,0));
    step();
    step();
    check("ar_pre_we",  {31'h0, we},         32'h1);
    check("ar_pre_cnt", {28'h0, retire_cnt}, {28'h0, exp_cnt});
    #2;
    rst_n = 1'b0;
    #1;
    check("ar_we",      {31'h0, we},         32'h0);
    check("ar_wb_addr", {27'h0, wb_addr},    32'h0);
    check("ar_wb_data", wb_data,             32'h0);
    check("ar_cnt",     {28'h0, retire_cnt}, 32'h0);
    check("ar_rs_hit",  {31'h0, fwd_rs_hit}, 32'h0);
    model_reset();
    // Held in reset across an edge with a valid instruction presented.
    @(posedge clk);
    #2;
    check("ar_hold_we", {31'h0, we}, 32'h0);
    rst_n = 1'b1;
    step();
    check("ar_post_we",      {31'h0, we},         32'h1);
    check("ar_post_wb_data", wb_data,             32'h55);
    check("ar_post_cnt",     {28'h0, retire_cnt}, 32'h0);
    step();
    check("ar_post_cnt2",    {28'h0, retire_cnt}, 32'h1);

    // ---- Counter wrap: 16 valid instructions from zero ----
    #1;
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    model_reset();
    apply(mk(1,0,0,0,2'd0,0,2'd0,5'd1,32'h0,32'h0,5'd0,5'd0,0,5'd0,32'h0,0,0));
    repeat (16) step();
    check("wrap_cnt15", {28'h0, retire_cnt}, 32'd15);
    apply(mk(0,0,0,0,2'd0,0,2'd0,5'd1,32'h0,32'h0,5'd0,5'd0,0,5'd0,32'h0,0,0));
    step();
    check("wrap_cnt0",  {28'h0, retire_cnt}, 32'd0);
    check("wrap_model", {28'h0, retire_cnt}, {28'h0, exp_cnt});
    step();
    check("wrap_hold",  {28'h0, retire_cnt}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_wb_stage

// File: doc/wb_stage.md
WB_STAGE -- requirements
Module: wb_stage

Interface
REQ-001 Parameter CNT_W, default 32, width of the retired-instruction counter.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 mem_valid  input  1  MEM stage presents a valid instruction this cycle.
REQ-005 mem_alu_result  input  32  ALU/address result from MEM.
REQ-006 mem_load_data  input  32  raw aligned word read from data memory.
REQ-007 mem_dest  input  5  destination register index.
REQ-008 mem_reg_write  input  1  instruction writes the register file.
REQ-009 mem_to_reg  input  1  1 = load result, 0 = ALU result.
REQ-010 mem_load_size  input  2  00 byte, 01 half, 10 word, 11 treated as word.
REQ-011 mem_load_unsigned  input  1  1 = zero-extend, 0 = sign-extend sub-word loads.
REQ-012 mem_byte_off  input  2  byte offset of the load address.
REQ-013 flush  input  1  discard the instruction being captured this cycle.
REQ-014 id_rs, id_rt  input  5 each  source indices currently decoded in ID.
REQ-015 we, wb_addr, wb_data  output  1/5/32  register-file write port.
REQ-016 fwd_rs_hit, fwd_rt_hit  output  1 each  same-cycle write-through hit for rs/rt.
REQ-017 fwd_data  output  32  write-through value (equals wb_data).
REQ-018 retire_cnt  output  CNT_W  count of retired valid instructions.

Function
REQ-019 At each rising edge, the block SHALL capture MEM inputs into one MEM/WB register; valid_q <= mem_valid & ~flush.
REQ-020 Load extraction SHALL precede the register, so we/wb_addr/wb_data are pure register outputs one cycle after capture.
REQ-021 Byte load SHALL select byte mem_byte_off (little-endian, byte 0 = bits 7:0), extended per mem_load_unsigned.
REQ-022 Half load SHALL select the half at mem_byte_off[1]; mem_byte_off[0] ignored; extended per mem_load_unsigned.
REQ-023 Word load (size 10 or 11) SHALL pass mem_load_data unchanged, ignoring offset and unsigned flag.
REQ-024 wb_data SHALL be the extracted load value when mem_to_reg=1, else mem_alu_result.
REQ-025 we SHALL be valid_q & reg_write_q & (wb_addr != 0); register 0 is never written.
REQ-026 fwd_rs_hit SHALL be we & (id_rs == wb_addr), combinational; fwd_rt_hit likewise with id_rt.
REQ-027 retire_cnt SHALL increment by 1 on every edge where valid_q=1, independent of reg_write, and wrap modulo 2^CNT_W.
REQ-028 flush and mem_valid together: flush wins, bubble captured, counter not incremented for it.
REQ-029 A bubble (mem_valid=0) SHALL still load data fields, but we stays 0.

Reset
REQ-030 While rst_n=0: valid_q=0, we=0, wb_addr=0, wb_data=0, retire_cnt=0, fwd hits=0, immediately and asynchronously.
REQ-031 Reset asserted mid-operation SHALL drop any pending write; first capture after release occurs on the first edge with rst_n=1.

Structure
REQ-032 Load-size encodings (LS_BYTE, LS_HALF, LS_WORD) SHALL live in shared package cpu_pkg.
REQ-033 Load extraction SHALL be one combinational sub-module, load_align (data, size, offset, unsigned -> 32-bit result).
REQ-034 No other sub-modules; no memories.

Verification
REQ-035 Load: data 0x8899AABB, byte, off=2, signed, dest 5 -> next cycle we=1, wb_addr=5, wb_data=0xFFFFFF99; unsigned -> 0x00000099.
REQ-036 Load: data 0x12348000, half, off=0, signed -> 0xFFFF8000; off=3 unsigned -> 0x00001234.
REQ-037 ALU write to dest 0, value 0xDEADBEEF, valid -> we=0, retire_cnt +1.
REQ-038 Valid ALU write dest 7, flush=1 same cycle -> we=0, retire_cnt unchanged; id_rs=7 -> fwd_rs_hit=0.
REQ-039 ALU write dest 9 value 0x55, id_rs=9, id_rt=9 -> fwd_rs_hit=fwd_rt_hit=1, fwd_data=0x55; CNT_W=4, 16 valid instrs from 0 -> retire_cnt=0.
REQ-040 Assert rst_n=0 between clock edges with we=1 -> we, wb_data, retire_cnt go 0 before next edge.
